// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite register-file memory slave with SLVERR on out-of-range words
// Ports: s_clk, rst_n (asynchronous, active-low)
//   write: write_address/AW_VALID/AW_READY, write_data/write_strb/W_VALID/W_READY,
//          B_RESP/B_VALID/B_READY
//   read:  read_address/AR_VALID/AR_READY, data_read/R_RESP/R_VALID/R_READY
// Define AXI_SLV_WSTRB_EN to honour write_strb; otherwise every write replaces the full word.
module axi_lite_mem_slave #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                    s_clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   write_address,
   input  logic                    AW_VALID,
   output logic                    AW_READY,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] write_strb,
   input  logic                    W_VALID,
   output logic                    W_READY,
   output logic [1:0]              B_RESP,
   output logic                    B_VALID,
   input  logic                    B_READY,
   input  logic [ADDR_WIDTH-1:0]   read_address,
   input  logic                    AR_VALID,
   output logic                    AR_READY,
   output logic [DATA_WIDTH-1:0]   data_read,
   output logic [1:0]              R_RESP,
   output logic                    R_VALID,
   input  logic                    R_READY
);
   localparam int NB  = DATA_WIDTH / 8;
   localparam int LSB = $clog2(NB);
   localparam int IW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   // one extra bit so DEPTH == 2**index_width still compares correctly
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a >> LSB} < (ADDR_WIDTH+1)'(DEPTH);
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  aw_done, w_done, aw_hs, w_hs, commit;
   logic                  aw_done_d, w_done_d, b_valid_d;
   logic [1:0]            b_resp_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
   logic [DATA_WIDTH-1:0] w_data_q, wr_data;
   logic [NB-1:0]         wr_mask;

   assign aw_hs   = AW_VALID && AW_READY;
   assign w_hs    = W_VALID && W_READY;
   // the second handshake (or both together) commits, taking whichever half is still on the bus
   assign commit  = (aw_done || aw_hs) && (w_done || w_hs);
   assign wr_addr = aw_done ? aw_addr_q : write_address;
   assign wr_data = w_done ? w_data_q : write_data;

`ifdef AXI_SLV_WSTRB_EN
   logic [NB-1:0] w_strb_q;
   always_ff @(posedge s_clk or negedge rst_n)
      if (!rst_n) w_strb_q <= '0;
      else if (w_hs) w_strb_q <= write_strb;
   assign wr_mask = w_done ? w_strb_q : write_strb;
`else
   logic unused_strb;
   assign unused_strb = ^write_strb;
   assign wr_mask     = '1;
`endif

   always_comb begin
      aw_done_d = !commit && (aw_done || aw_hs);
      w_done_d  = !commit && (w_done || w_hs);
      b_valid_d = commit || (B_VALID && !B_READY);
      b_resp_d  = commit ? (in_range(wr_addr) ? OKAY : SLVERR) : B_RESP;
   end

   always_ff @(posedge s_clk or negedge rst_n)
      if (!rst_n) begin
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         B_VALID   <= 1'b0;
         B_RESP    <= OKAY;
         AW_READY  <= 1'b0;
         W_READY   <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
      end else begin
         aw_done  <= aw_done_d;
         w_done   <= w_done_d;
         B_VALID  <= b_valid_d;
         B_RESP   <= b_resp_d;
         AW_READY <= !aw_done_d && !b_valid_d;
         W_READY  <= !w_done_d && !b_valid_d;
         if (aw_hs) aw_addr_q <= write_address;
         if (w_hs) w_data_q <= write_data;
      end

   // every byte of word i resets to {i[3:0], i[3:0]}
   always_ff @(posedge s_clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < DEPTH; i++) mem[i] <= {NB{{2{4'(i)}}}};
      else if (commit && in_range(wr_addr))
         for (int k = 0; k < NB; k++)
            if (wr_mask[k]) mem[IW'(wr_addr >> LSB)][8*k +: 8] <= wr_data[8*k +: 8];

   r_state_t              r_state, r_state_d;
   logic [DATA_WIDTH-1:0] r_data_d, rd_word;
   logic [1:0]            r_resp_d;

   // sampled before this edge's write lands, so a colliding read sees the old word
   assign rd_word = in_range(read_address) ? mem[IW'(read_address >> LSB)] : '0;

   always_comb begin
      r_state_d = r_state;
      r_data_d  = data_read;
      r_resp_d  = R_RESP;
      if (r_state == R_IDLE && AR_VALID && AR_READY) begin
         r_state_d = R_DATA;
         r_data_d  = rd_word;
         r_resp_d  = in_range(read_address) ? OKAY : SLVERR;
      end else if (r_state == R_DATA && R_READY) begin
         r_state_d = R_IDLE;
         r_data_d  = '0;
         r_resp_d  = OKAY;
      end
   end

   always_ff @(posedge s_clk or negedge rst_n)
      if (!rst_n) begin
         r_state   <= R_IDLE;
         AR_READY  <= 1'b0;
         R_VALID   <= 1'b0;
         data_read <= '0;
         R_RESP    <= OKAY;
      end else begin
         r_state   <= r_state_d;
         AR_READY  <= r_state_d == R_IDLE;
         R_VALID   <= r_state_d == R_DATA;
         data_read <= r_data_d;
         R_RESP    <= r_resp_d;
      end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: directed and randomized checks of axi_lite_mem_slave against a word-array model
module tb_axi_lite_mem_slave;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [7:0]  write_address = '0, read_address = '0;
   logic [31:0] write_data = '0, data_read;
   logic [3:0]  write_strb = '0;
   logic        AW_VALID = 1'b0, W_VALID = 1'b0, B_READY = 1'b0, AR_VALID = 1'b0, R_READY = 1'b0;
   logic        AW_READY, W_READY, B_VALID, AR_READY, R_VALID;
   logic [1:0]  B_RESP, R_RESP;
   int          passed = 0, total = 0;
   logic [31:0] model [16];

`ifdef AXI_SLV_WSTRB_EN
   localparam bit STRB_EN = 1'b1;
`else
   localparam bit STRB_EN = 1'b0;
`endif

   axi_lite_mem_slave dut (
      .s_clk(clk), .rst_n(rst_n),
      .write_address(write_address), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
      .write_data(write_data), .write_strb(write_strb), .W_VALID(W_VALID), .W_READY(W_READY),
      .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
      .read_address(read_address), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
      .data_read(data_read), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) model[i] = 32'h11111111 * i;
   endfunction

   function automatic logic [1:0] exp_resp(input logic [7:0] a);
      return (int'(a) / 4 < 16) ? 2'b00 : 2'b10;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      int i;
      i = int'(a) / 4;
      if (i < 16) return model[i];
      return 32'h0;
   endfunction

   function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      int i;
      i = int'(a) / 4;
      if (i < 16)
         for (int k = 0; k < 4; k++)
            if (s[k] || !STRB_EN) model[i][8*k +: 8] = d[8*k +: 8];
   endfunction

   task automatic do_read(input logic [7:0] a, input int stall);
      logic [31:0] ed;
      logic [1:0]  er;
      int          n;
      ed = model_read(a);
      er = exp_resp(a);
      read_address = a;
      AR_VALID = 1'b1;
      R_READY = 1'b0;
      n = 0;
      while (!AR_READY && n < 20) begin
         tick();
         n++;
      end
      chk("ar_ready_wait", AR_READY, 1);
      tick();
      AR_VALID = 1'b0;
      read_address = 8'($urandom);
      for (int i = 0; i <= stall; i++) begin
         chk("r_valid", R_VALID, 1);
         chk("r_data", data_read, ed);
         chk("r_resp", R_RESP, er);
         chk("ar_ready_busy", AR_READY, 0);
         if (i == stall) R_READY = 1'b1;
         tick();
      end
      R_READY = 1'b0;
      chk("r_valid_drop", R_VALID, 0);
      chk("r_data_idle", data_read, 0);
      chk("ar_ready_back", AR_READY, 1);
   endtask

   // order: 0 AW+W together, 1 W first then AW after gap cycles, 2 AW first then W after gap
   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order, input int gap, input int bstall);
      bit ad, wd, ah, wh;
      int n;
      ad = 0;
      wd = 0;
      n = 0;
      B_READY = 1'b0;
      while (!(ad && wd) && n < 40) begin
         if (!ad && !AW_VALID && (order != 1 || n >= gap)) begin
            write_address = a;
            AW_VALID = 1'b1;
         end
         if (!wd && !W_VALID && (order != 2 || n >= gap)) begin
            write_data = d;
            write_strb = s;
            W_VALID = 1'b1;
         end
         ah = AW_VALID && AW_READY;
         wh = W_VALID && W_READY;
         tick();
         n++;
         if (ah) begin
            AW_VALID = 1'b0;
            write_address = 8'($urandom);
            ad = 1;
         end
         if (wh) begin
            W_VALID = 1'b0;
            write_data = $urandom;
            write_strb = 4'($urandom);
            wd = 1;
         end
         if (!(ad && wd)) chk("b_early", B_VALID, 0);
      end
      chk("w_handshakes", {30'd0, ad, wd}, 3);
      model_write(a, d, s);
      for (int i = 0; i <= bstall; i++) begin
         chk("b_valid", B_VALID, 1);
         chk("b_resp", B_RESP, exp_resp(a));
         chk("aw_ready_busy", AW_READY, 0);
         chk("w_ready_busy", W_READY, 0);
         if (i == bstall) B_READY = 1'b1;
         tick();
      end
      B_READY = 1'b0;
      chk("b_valid_drop", B_VALID, 0);
      chk("aw_ready_back", AW_READY, 1);
      chk("w_ready_back", W_READY, 1);
   endtask

   initial begin
      model_reset();
      repeat (3) tick();
      chk("rst_ar_ready", AR_READY, 0);
      chk("rst_aw_ready", AW_READY, 0);
      chk("rst_w_ready", W_READY, 0);
      chk("rst_b_valid", B_VALID, 0);
      chk("rst_r_valid", R_VALID, 0);
      chk("rst_b_resp", B_RESP, 0);
      chk("rst_r_resp", R_RESP, 0);
      chk("rst_data_read", data_read, 0);
      #2 rst_n = 1'b1;
      #1 chk("ar_ready_before_edge", AR_READY, 0);
      tick();
      chk("ar_ready_first_edge", AR_READY, 1);
      chk("aw_ready_first_edge", AW_READY, 1);
      chk("w_ready_first_edge", W_READY, 1);

      do_read(8'h0C, 0);
      do_write(8'h08, 32'hDEADBEEF, 4'b0011, 1, 3, 0);
      do_read(8'h08, 0);
      do_read(8'h40, 0);
      do_write(8'h44, 32'hA5A5A5A5, 4'hF, 0, 0, 1);
      do_read(8'h04, 0);
      do_read(8'h10, 5);

      // read captured on the same edge as a write commit to the same word
      write_address = 8'h04; write_data = 32'h12345678; write_strb = 4'hF;
      AW_VALID = 1'b1; W_VALID = 1'b1; B_READY = 1'b1;
      read_address = 8'h04; AR_VALID = 1'b1; R_READY = 1'b1;
      chk("coll_ar_ready", AR_READY, 1);
      chk("coll_aw_ready", AW_READY, 1);
      chk("coll_w_ready", W_READY, 1);
      tick();
      AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
      chk("coll_r_valid", R_VALID, 1);
      chk("coll_old_data", data_read, model_read(8'h04));
      chk("coll_b_valid", B_VALID, 1);
      chk("coll_b_resp", B_RESP, 0);
      model_write(8'h04, 32'h12345678, 4'hF);
      tick();
      B_READY = 1'b0; R_READY = 1'b0;
      chk("coll_r_done", R_VALID, 0);
      chk("coll_b_done", B_VALID, 0);
      do_read(8'h04, 0);

      // asynchronous reset while both response channels are pending
      write_address = 8'h08; write_data = 32'hCAFEF00D; write_strb = 4'hF;
      AW_VALID = 1'b1; W_VALID = 1'b1;
      read_address = 8'h0C; AR_VALID = 1'b1;
      tick();
      AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
      chk("pre_rst_b_valid", B_VALID, 1);
      chk("pre_rst_r_valid", R_VALID, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_b_valid", B_VALID, 0);
      chk("async_r_valid", R_VALID, 0);
      chk("async_data_read", data_read, 0);
      chk("async_ar_ready", AR_READY, 0);
      chk("async_aw_ready", AW_READY, 0);
      tick();
      rst_n = 1'b1;
      model_reset();
      tick();
      do_read(8'h08, 0);

      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 1) == 0)
            do_read(8'($urandom_range(0, 8'h4F)), int'($urandom_range(0, 2)));
         else
            do_write(8'($urandom_range(0, 8'h4F)), $urandom, 4'($urandom),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end
      for (int i = 0; i < 16; i++) do_read(8'(i * 4), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
